// File: rtl/feature_map_stream_tx.sv
// Raster-order streamer for a square feature map held in single-port memory.
// Emits pixel_valid/pixel_out/sof two cycles behind each memory read.
module feature_map_stream_tx #(
  parameter int unsigned input_y    = 64,
  parameter int unsigned data_width = 16,
  parameter int unsigned addr_width = 12,
  parameter int unsigned line_gap   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  output logic                  mem_rd_en,
  output logic [addr_width-1:0] mem_addr,
  input  logic [data_width-1:0] mem_rd_data,
  output logic [data_width-1:0] pixel_out,
  output logic                  pixel_valid,
  output logic                  sof,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned col_w = (input_y > 1) ? $clog2(input_y) : 1;
  localparam int unsigned gap_w = (line_gap > 0) ? $clog2(line_gap + 1) : 1;
  localparam logic [col_w-1:0] last_idx = col_w'(input_y - 1);

  typedef enum logic [1:0] {
    s_idle,
    s_read,
    s_gap,
    s_drain
  } state_t;

  state_t                state_q, state_n;
  logic [addr_width-1:0] addr_q, addr_n, rd_addr;
  logic [col_w-1:0]      col_q, col_n;
  logic [col_w-1:0]      row_q, row_n;
  logic [gap_w-1:0]      gap_q, gap_n;
  logic [1:0]            drain_q, drain_n;
  logic                  busy_n, done_n, issue, first_n;
  logic                  first_q, rd_en_d1, first_d1;

  // Next-state, read-issue and counter update logic
  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    col_n   = col_q;
    row_n   = row_q;
    gap_n   = gap_q;
    drain_n = drain_q;
    busy_n  = busy;
    done_n  = 1'b0;
    issue   = 1'b0;
    rd_addr = addr_q;
    first_n = 1'b0;

    case (state_q)
      s_idle: begin
        busy_n = 1'b0;
        if (start && !busy) begin
          state_n = s_read;
          busy_n  = 1'b1;
          addr_n  = '0;
          col_n   = '0;
          row_n   = '0;
          issue   = !pause;
        end
      end
      s_read: issue = !pause;
      s_gap: begin
        if (!pause) begin
          if (gap_q == gap_w'(1)) begin
            row_n   = row_q + col_w'(1);
            state_n = s_read;
          end else begin
            gap_n = gap_q - gap_w'(1);
          end
        end
      end
      s_drain: begin
        drain_n = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          drain_n = 2'd0;
          done_n  = 1'b1;
          state_n = s_idle;
        end
      end
      default: state_n = s_idle;
    endcase

    // Idle address output shows the next address to be read, so a pause holds it
    rd_addr = addr_n;
    first_n = issue && (col_n == '0) && (row_n == '0);
    if (issue) begin
      addr_n = addr_n + addr_width'(1);
      if (col_n == last_idx) begin
        col_n = '0;
        if (row_n == last_idx) begin
          state_n = s_drain;
          drain_n = 2'd0;
        end else if (line_gap > 0) begin
          state_n = s_gap;
          gap_n   = gap_w'(line_gap);
        end else begin
          row_n = row_n + col_w'(1);
        end
      end else begin
        col_n = col_n + col_w'(1);
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= s_idle;
      addr_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      gap_q       <= '0;
      drain_q     <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      first_q     <= 1'b0;
      rd_en_d1    <= 1'b0;
      first_d1    <= 1'b0;
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      pixel_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      col_q       <= col_n;
      row_q       <= row_n;
      gap_q       <= gap_n;
      drain_q     <= drain_n;
      mem_rd_en   <= issue;
      mem_addr    <= rd_addr;
      first_q     <= first_n;
      rd_en_d1    <= mem_rd_en;
      first_d1    <= first_q;
      pixel_valid <= rd_en_d1;
      sof         <= first_d1;
      if (rd_en_d1) pixel_out <= mem_rd_data;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule
